// File: rtl/branch_redirect_if.sv
// Purpose: bundles the EX-side resolve inputs and fetch-side redirect
//          outputs of the branch redirect controller.
// Ports:   master = pipeline/fetch side driving EX results and fetch_ready;
//          slave  = redirect controller producing pc_sel/flush/busy/count.
interface branch_redirect_if #(
  parameter int PC_W = 16
);
  // EX stage resolve information
  logic            ex_valid;
  logic            stall_in;
  logic [2:0]      brchSig;
  logic            sf;
  logic            zf;
  logic            of;
  logic            cf;
  logic            ex_is_jump;
  logic [PC_W-1:0] ex_target;
  // fetch stage handshake and pipeline control
  logic            fetch_ready;
  logic            pc_sel;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic            redirect_busy;
  logic [15:0]     taken_cnt;

  modport master (
    output ex_valid, stall_in, brchSig, sf, zf, of, cf, ex_is_jump, ex_target,
           fetch_ready,
    input  pc_sel, redirect_pc, flush_ifid, flush_idex, redirect_busy, taken_cnt
  );

  modport slave (
    input  ex_valid, stall_in, brchSig, sf, zf, of, cf, ex_is_jump, ex_target,
           fetch_ready,
    output pc_sel, redirect_pc, flush_ifid, flush_idex, redirect_busy, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Purpose: resolves taken branches/jumps in EX, steers fetch to the target
//          and squashes IF/ID + ID/EX for FLUSH_CYC cycles.
// Latency: accept in cycle T -> pc_sel/flushes visible at T+1 (all outputs registered).
// Backpressure: REDIRECT holds until fetch_ready; EX is not accepted while busy.
// Ports:   clk, rst (sync, active-high), bus (branch_redirect_if.slave).
module branch_redirect_ctrl #(
  parameter int PC_W      = 16,
  parameter int FLUSH_CYC = 2    // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  branch_redirect_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // REDIRECT already accounts for one flush cycle, FLUSH covers the rest.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  state_t          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]     taken_cnt_q, taken_cnt_d;
  logic            pc_sel_q, pc_sel_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;

  logic cond;
  logic take;
  logic accept;

  // overflow/carry are reserved for future condition codes
  logic unused_flags;
  assign unused_flags = &{1'b0, bus.of, bus.cf};

  always_comb begin
    cond = 1'b0;
    case (bus.brchSig)
      3'b010:  cond = bus.zf;    // BEQ
      3'b101:  cond = ~bus.zf;   // BNE
      3'b100:  cond = bus.sf;    // BLT
      3'b011:  cond = ~bus.sf;   // BGE
      default: cond = 1'b0;
    endcase
  end

  assign take   = bus.ex_is_jump | cond;
  assign accept = bus.ex_valid & ~bus.stall_in & (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    redirect_pc_d = redirect_pc_q;
    taken_cnt_d   = taken_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && take) begin
          state_d       = REDIRECT;
          redirect_pc_d = bus.ex_target;
          if (taken_cnt_q != 16'hFFFF) begin
            taken_cnt_d = taken_cnt_q + 16'd1;
          end
        end
      end
      REDIRECT: begin
        if (bus.fetch_ready) begin
          if (FLUSH_CYC == 1) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q <= 4'd1) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with it.
  assign pc_sel_d = (state_d == REDIRECT);
  assign flush_d  = (state_d != IDLE);
  assign busy_d   = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fcnt_q        <= 4'd0;
      redirect_pc_q <= '0;
      taken_cnt_q   <= 16'd0;
      pc_sel_q      <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      redirect_pc_q <= redirect_pc_d;
      taken_cnt_q   <= taken_cnt_d;
      pc_sel_q      <= pc_sel_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.pc_sel        = pc_sel_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.flush_ifid    = flush_q;
  assign bus.flush_idex    = flush_q;
  assign bus.redirect_busy = busy_q;
  assign bus.taken_cnt     = taken_cnt_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the PC redirect and pipeline squash after a branch or jump resolves in EX.
- Evaluates the branch-condition code against the ALU flags.
- On a taken outcome, drives the fetch-stage PC mux to the target, holds the redirect until fetch accepts it, then flushes IF/ID and ID/EX for a fixed number of cycles.
- Also keeps a saturating taken-redirect counter for perf debug.

Parameters:
- PC_W, 16, width of PC and branch target.
- FLUSH_CYC, 2, total cycles flush_ifid/flush_idex stay asserted per redirect (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX holds a valid control-flow instruction this cycle.
- stall_in  in  1  pipeline freeze; EX contents are not consumed.
- brchSig  in  3  branch condition code from control.
- sf  in  1  ALU sign flag.
- zf  in  1  ALU zero flag.
- of  in  1  ALU overflow flag (unused by current codes, reserved).
- cf  in  1  ALU carry flag (unused by current codes, reserved).
- ex_is_jump  in  1  unconditional jump/JAL/JR in EX.
- ex_target  in  PC_W  resolved target address.
- fetch_ready  in  1  instruction memory accepts a new PC this cycle.
- pc_sel  out  1  1 = fetch uses redirect_pc.
- redirect_pc  out  PC_W  latched target.
- flush_ifid  out  1  squash IF/ID register.
- flush_idex  out  1  squash ID/EX register.
- redirect_busy  out  1  FSM not IDLE.
- taken_cnt  out  16  saturating count of redirects issued.

Behaviour:
- All outputs are registered. Reset (any state, including mid-redirect) forces:
  - state IDLE;
  - pc_sel, flush_ifid, flush_idex, redirect_busy = 0;
  - redirect_pc = 0 and taken_cnt = 0.
- Accept: ex_valid & ~stall_in & state==IDLE. No accept occurs outside IDLE; wrong-path EX instructions are ignored.
- Condition (cond):
  - 010 BEQ: taken when zf = 1.
  - 101 BNE: taken when zf = 0.
  - 100 BLT: taken when sf = 1.
  - 011 BGE: taken when sf = 0.
  - 000, 001, 110, 111: never taken.
- take = ex_is_jump | cond. ex_is_jump overrides brchSig.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - On accept & take in cycle T, latch redirect_pc <= ex_target, increment taken_cnt, and go to REDIRECT.
  - Accept & ~take: stay in IDLE with no output change.
- REDIRECT:
  - Outputs: pc_sel = 1, flush_ifid = 1, flush_idex = 1, redirect_busy = 1. These are first visible at T+1.
  - If fetch_ready = 0: stay in REDIRECT, hold all outputs and redirect_pc stable.
  - If fetch_ready = 1 and FLUSH_CYC = 1: go to IDLE.
  - If fetch_ready = 1 and FLUSH_CYC > 1: go to FLUSH and load flush counter = FLUSH_CYC-1.
- FLUSH:
  - Outputs: pc_sel = 0, flushes = 1, redirect_busy = 1.
  - Counter decrements each cycle; go to IDLE when it reaches 1 (FLUSH_CYC-1 cycles in FLUSH).
  - fetch_ready and stall_in are ignored in this state.
- Latency: accept at T → pc_sel at T+1. Minimum redirect occupancy = FLUSH_CYC cycles.
- Next accept is possible the first cycle the FSM is back in IDLE, with no bubble.
- taken_cnt: +1 per taken accept, saturates at 0xFFFF with no wrap.
- stall_in = 1 in IDLE blocks accept regardless of ex_valid/flags. stall_in has no effect in REDIRECT/FLUSH.
- redirect_pc changes only on a taken accept.

Test Plan:
- Taken BEQ:
  - Stimulus: brchSig=010, zf=1, ex_valid=1, target=0x0040, fetch_ready=1, FLUSH_CYC=2.
  - Response: T+1 pc_sel=1, redirect_pc=0x0040, flushes=1; T+2 pc_sel=0, flushes=1; T+3 all 0; taken_cnt=1.
- Not taken / non-branch codes:
  - Stimulus: BNE with zf=1, BLT with sf=0, brchSig=110 with sf=1, zf=1.
  - Response: pc_sel, flushes and redirect_busy stay 0; taken_cnt stays 0.
- Jump override:
  - Stimulus: ex_is_jump=1, brchSig=000, target=0x1234.
  - Response: redirect at T+1 to 0x1234.
- Fetch backpressure:
  - Stimulus: taken BGE (sf=0), fetch_ready=0 for 3 cycles then 1.
  - Response: pc_sel/flushes held for 4 cycles with redirect_pc stable, then 1 FLUSH cycle, then IDLE.
  - Also drive a second ex_valid during the hold: it is ignored.
- Stall gating:
  - Stimulus: taken BEQ with stall_in=1 for 2 cycles, then stall_in=0.
  - Response: no redirect until stall drops; redirect one cycle after release.
- Reset and saturation:
  - Assert rst while in REDIRECT: next cycle all outputs 0, state IDLE.
  - Preload 0xFFFE taken redirects (or force): counter reaches 0xFFFF and stays at 0xFFFF after one more taken accept.
